// File: rtl/lsu_mem_ctrl.sv
// Load/store unit placed in front of a 32-bit, word-addressed data memory
// that has a registered read port. It takes one load or store at a time,
// computes rs1 + sext(imm), and checks the access for faults. It then drives
// the memory ports. Byte and halfword stores use a read-modify-write. Loads
// return their data sign- or zero-extended.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Once the unit asserts resp_valid, resp_valid and
// resp_data/resp_rd/resp_fault hold steady until resp_ready is seen. The
// unit asserts req_ready only in IDLE, so at most one operation is in flight.
module lsu_mem_ctrl #(
  parameter int          ADDR_W    = 5,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_rs1,
  input  logic [11:0]       req_imm,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_fault,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  // Memory size in bytes. It is one bit wider than the offset so that the
  // range compare also works when the memory spans the full 32-bit space.
  localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_W;

  state_t r_state, w_state_nxt;

  // Request fields captured at accept and used by the later states.
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [15:0]       r_rs2;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_index;

  // Registered outputs.
  logic              r_resp_valid, r_resp_fault, r_wr_en, r_rd_en;
  logic [DATA_W-1:0] r_resp_data, r_wr_data;
  logic [4:0]        r_resp_rd;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;

  logic              w_resp_valid_nxt, w_resp_fault_nxt, w_wr_en_nxt, w_rd_en_nxt;
  logic [DATA_W-1:0] w_resp_data_nxt, w_wr_data_nxt;
  logic [4:0]        w_resp_rd_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt, w_rd_addr_nxt;
  logic              w_accept;

  // Address and fault decode for the request currently on the input.
  logic [31:0]       w_ea, w_off;
  logic              w_oor, w_misal, w_bad_f3, w_fault;
  logic [ADDR_W-1:0] w_index;

  assign w_ea    = req_rs1 + {{20{req_imm[11]}}, req_imm};
  assign w_off   = w_ea - BASE_ADDR;
  assign w_index = w_off[ADDR_W+1:2];
  assign w_oor   = {1'b0, w_off} >= MEM_BYTES;
  assign w_misal = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (w_off[1:0] != 2'b00));
  // Legal loads: LB/LH/LW/LBU/LHU. Legal stores: SB/SH/SW.
  assign w_bad_f3 = req_is_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
  assign w_fault  = w_oor || w_misal || w_bad_f3;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  // Lane extraction for loads and lane merge for sub-word stores, both taken
  // from the word the memory returns in RD_WAIT.
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load, w_merged;

  // Extend the loaded lane, and build the merged write word for SB/SH.
  always_comb begin
    w_byte   = rd_data[{r_lane, 3'b000} +: 8];
    w_half   = rd_data[{r_lane[1], 4'b0000} +: 16];
    w_load   = rd_data;
    w_merged = rd_data;
    case (r_funct3[1:0])
      2'b00: begin
        w_load = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_rs2[7:0];
      end
      2'b01: begin
        w_load = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_rs2;
      end
      default: ;
    endcase
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_fault_nxt = r_resp_fault;
    w_resp_data_nxt  = r_resp_data;
    w_resp_rd_nxt    = r_resp_rd;
    w_wr_en_nxt      = 1'b0;
    w_rd_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_rd_addr_nxt    = r_rd_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_resp_rd_nxt    = req_rd;
          w_resp_data_nxt  = '0;
          w_resp_fault_nxt = w_fault;
          if (w_fault) begin
            w_resp_valid_nxt = 1'b1;
            w_state_nxt      = S_RESP;
          end else if (req_is_store && (req_funct3[1:0] == 2'b10)) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = w_index;
            w_wr_data_nxt = req_rs2;
            w_state_nxt   = S_WR_ISSUE;
          end else begin
            // Loads and sub-word stores both start with a read.
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = w_index;
            w_state_nxt   = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_is_store) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_index;
          w_wr_data_nxt = w_merged;
          w_state_nxt   = S_WR_ISSUE;
        end else begin
          w_resp_data_nxt  = w_load;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end
      end
      S_WR_ISSUE: begin
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture the request fields that later states need.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_rs2      <= '0;
      r_lane     <= 2'b00;
      r_index    <= '0;
    end else if (w_accept) begin
      r_is_store <= req_is_store;
      r_funct3   <= req_funct3;
      r_rs2      <= req_rs2[15:0];
      r_lane     <= w_off[1:0];
      r_index    <= w_index;
    end
  end

  // Output registers. Reset clears them at once, which drops any
  // operation that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
    end else begin
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_fault <= w_resp_fault_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_rd    <= w_resp_rd_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl. It contains a behavioural 32-word memory with a
// registered read, a table of directed vectors, hand-written reset and
// back-pressure sequences, and random operations checked against a
// reference model built from plain arithmetic.
module tb_lsu_mem_ctrl;

  localparam int          ADDR_W = 5;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic [11:0] req_imm;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        wr_en, rd_en;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [11:0] imm;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        fault;
    logic [31:0] data;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[18];

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_imm(req_imm),
    .req_rs2(req_rs2), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // ---------------- memory with backdoor preload ----------------
  logic [31:0] mem[32];
  logic [31:0] model_mem[32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // ---------------- port activity monitor ----------------
  int          rd_pulses = 0, wr_pulses = 0, overlap = 0;
  logic [4:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_pulses++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
    if (rd_en) begin
      rd_pulses++;
      last_rd_addr = rd_addr;
    end
    if (wr_en && rd_en) overlap++;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bd_write(input int a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = a[4:0];
    bd_data = d;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                              input logic [11:0] imm, input logic [31:0] rs2, input logic [4:0] rd,
                              input logic fault, input logic [31:0] data, input int lat,
                              input int rd_n, input int wr_n, input logic [4:0] addr,
                              input logic [31:0] wdata);
    vec_t v;
    v.st = st; v.f3 = f3; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2; v.rd = rd;
    v.fault = fault; v.data = data; v.lat = lat; v.rd_n = rd_n; v.wr_n = wr_n;
    v.addr = addr; v.wdata = wdata;
    return v;
  endfunction

  // Reference model: works from the byte offset, the access size and the
  // lane shift using plain integer arithmetic. It also keeps model_mem current.
  task automatic model_op(input vec_t q, output vec_t v);
    longint imm_v, ea, off, size, sh, mask, word, val, nw;
    int     idx;
    bit     legal, fault;
    v = q;
    imm_v = (q.imm >= 12'd2048) ? longint'(q.imm) - 4096 : longint'(q.imm);
    ea    = (longint'(q.rs1) + imm_v) & 64'hFFFF_FFFF;
    off   = (ea - longint'(BASE)) & 64'hFFFF_FFFF;
    case (q.f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    legal = (size != 0) && (q.st ? (q.f3 < 3'd3) : (q.f3 != 3'd6));
    fault = !legal || (off >= 128) || ((off % (legal ? size : 1)) != 0);
    v.fault = fault; v.data = '0; v.rd_n = 0; v.wr_n = 0; v.addr = '0; v.wdata = '0;
    if (fault) begin
      v.lat = 1;
    end else begin
      idx    = int'(off / 4);
      v.addr = idx[4:0];
      word   = longint'(model_mem[idx]);
      sh     = (off % 4) * 8;
      mask   = (64'd1 << (8 * size)) - 1;
      if (!q.st) begin
        val = (word >> sh) & mask;
        if (q.f3 < 3'd4 && size < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
        v.data = val[31:0];
        v.lat  = 3;
        v.rd_n = 1;
      end else begin
        nw = (word & ~(mask << sh)) | ((longint'(q.rs2) & mask) << sh);
        v.wdata = nw[31:0];
        model_mem[idx] = nw[31:0];
        v.wr_n = 1;
        v.rd_n = (size < 4) ? 1 : 0;
        v.lat  = (size < 4) ? 4 : 2;
      end
    end
  endtask

  // Driver plus checker for one full operation. hold is the number of cycles
  // that resp_ready stays low after resp_valid appears.
  task automatic run_op(input vec_t v, input int hold, input string tag);
    int rd0, wr0, w, lat;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    req_is_store = v.st; req_funct3 = v.f3; req_rs1 = v.rs1; req_imm = v.imm;
    req_rs2 = v.rs2; req_rd = v.rd;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " fault"}, {31'b0, resp_fault}, {31'b0, v.fault});
    chk({tag, " data"}, resp_data, v.data);
    chk({tag, " rd"}, {27'b0, resp_rd}, {27'b0, v.rd});
    chk({tag, " busy"}, {31'b0, req_ready}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, " hold data"}, resp_data, v.data);
      chk({tag, " hold busy"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " resp cleared"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, " rd pulses"}, 32'(rd_pulses - rd0), 32'(v.rd_n));
    chk({tag, " wr pulses"}, 32'(wr_pulses - wr0), 32'(v.wr_n));
    if (v.rd_n > 0) chk({tag, " rd_addr"}, {27'b0, last_rd_addr}, {27'b0, v.addr});
    if (v.wr_n > 0) begin
      chk({tag, " wr_addr"}, {27'b0, last_wr_addr}, {27'b0, v.addr});
      chk({tag, " wr_data"}, last_wr_data, v.wdata);
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t q, v;
    int   wr0, lat, imm_s;

    // Directed vectors; expected values worked out by hand from the
    // preloaded memory image.
    tbl[0]  = mk(1, 3'd2, 32'h20,       12'h000, 32'h6,         5'd3,  0, 32'h0,         2, 0, 1, 5'd8,  32'h6);
    tbl[1]  = mk(0, 3'd2, 32'h24,       12'hFFC, 32'h0,         5'd7,  0, 32'h6,         3, 1, 0, 5'd8,  32'h0);
    tbl[2]  = mk(0, 3'd0, 32'h2D,       12'h000, 32'h0,         5'd1,  0, 32'hFFFF_FFF0, 3, 1, 0, 5'd11, 32'h0);
    tbl[3]  = mk(0, 3'd4, 32'h2D,       12'h000, 32'h0,         5'd2,  0, 32'h0000_00F0, 3, 1, 0, 5'd11, 32'h0);
    tbl[4]  = mk(0, 3'd1, 32'h2E,       12'h000, 32'h0,         5'd4,  0, 32'hFFFF_8081, 3, 1, 0, 5'd11, 32'h0);
    tbl[5]  = mk(0, 3'd5, 32'h2E,       12'h000, 32'h0,         5'd5,  0, 32'h0000_8081, 3, 1, 0, 5'd11, 32'h0);
    tbl[6]  = mk(1, 3'd0, 32'h3D,       12'h000, 32'h55,        5'd6,  0, 32'h0,         4, 1, 1, 5'd15, 32'h1122_5544);
    tbl[7]  = mk(0, 3'd2, 32'h22,       12'h000, 32'h0,         5'd8,  1, 32'h0,         1, 0, 0, 5'd0,  32'h0);
    tbl[8]  = mk(1, 3'd1, 32'h81,       12'h000, 32'h1234,      5'd9,  1, 32'h0,         1, 0, 0, 5'd0,  32'h0);
    tbl[9]  = mk(0, 3'd2, 32'h80,       12'h000, 32'h0,         5'd10, 1, 32'h0,         1, 0, 0, 5'd0,  32'h0);
    tbl[10] = mk(0, 3'd3, 32'h40,       12'h000, 32'h0,         5'd11, 1, 32'h0,         1, 0, 0, 5'd0,  32'h0);
    tbl[11] = mk(0, 3'd2, 32'hFFFF_FFFC,12'h008, 32'h0,         5'd12, 0, 32'hCAFE_F00D, 3, 1, 0, 5'd1,  32'h0);
    tbl[12] = mk(1, 3'd4, 32'h10,       12'h000, 32'h77,        5'd13, 1, 32'h0,         1, 0, 0, 5'd0,  32'h0);
    tbl[13] = mk(0, 3'd2, 32'h7C,       12'h000, 32'h0,         5'd14, 0, 32'h1357_9BDF, 3, 1, 0, 5'd31, 32'h0);
    tbl[14] = mk(0, 3'd2, 32'h0,        12'hFFC, 32'h0,         5'd15, 1, 32'h0,         1, 0, 0, 5'd0,  32'h0);
    tbl[15] = mk(0, 3'd2, 32'h3C,       12'h000, 32'h0,         5'd16, 0, 32'h1122_5544, 3, 1, 0, 5'd15, 32'h0);
    tbl[16] = mk(1, 3'd1, 32'h3E,       12'h000, 32'hABCD_BEEF, 5'd17, 0, 32'h0,         4, 1, 1, 5'd15, 32'hBEEF_5544);
    tbl[17] = mk(0, 3'd1, 32'h3E,       12'h000, 32'h0,         5'd18, 0, 32'hFFFF_BEEF, 3, 1, 0, 5'd15, 32'h0);

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_rs1 = '0; req_imm = '0; req_rs2 = '0; req_rd = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset wr_en", {31'b0, wr_en}, 32'd0);
    chk("reset rd_en", {31'b0, rd_en}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset dbg_state", {29'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    bd_write(1,  32'hCAFE_F00D);
    bd_write(2,  32'h5A5A_1234);
    bd_write(11, 32'h8081_F0A5);
    bd_write(15, 32'h1122_3344);
    bd_write(31, 32'h1357_9BDF);

    for (int i = 0; i < 18; i++) run_op(tbl[i], (i == 2) ? 1 : 0, $sformatf("vec%0d", i));

    // Back-pressure: resp_ready stays low for 5 cycles while the response
    // waits. The next request is already pending when resp_ready rises.
    req_is_store = 1'b0; req_funct3 = 3'd2; req_rs1 = 32'h2C; req_imm = '0; req_rd = 5'd20;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk("bp valid", {31'b0, resp_valid}, 32'd1);
      chk("bp data", resp_data, 32'h8081_F0A5);
      chk("bp busy", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_funct3 = 3'd2; req_rs1 = 32'h22; req_rd = 5'd21; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b resp cleared", {31'b0, resp_valid}, 32'd0);
    chk("b2b ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b accepted", {31'b0, req_ready}, 32'd0);
    chk("b2b fault valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b fault", {31'b0, resp_fault}, 32'd1);
    chk("b2b rd", {27'b0, resp_rd}, 32'd21);
    @(posedge clk); #1;

    // Reset arrives while a load waits for memory data.
    wr0 = wr_pulses;
    req_is_store = 1'b0; req_funct3 = 3'd2; req_rs1 = 32'h08; req_imm = '0; req_rd = 5'd4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("midrst rd_en", {31'b0, rd_en}, 32'd0);
    chk("midrst wr_en", {31'b0, wr_en}, 32'd0);
    chk("midrst rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("midrst resp_rd", {27'b0, resp_rd}, 32'd0);
    chk("midrst resp_data", resp_data, 32'd0);
    chk("midrst wr_addr", {27'b0, wr_addr}, 32'd0);
    chk("midrst wr_data", wr_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst no resp", {31'b0, resp_valid}, 32'd0);
    chk("midrst no write", 32'(wr_pulses - wr0), 32'd0);

    // Random operations checked against the reference model.
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = $urandom;
      bd_write(i, model_mem[i]);
    end
    for (int n = 0; n < 200; n++) begin
      q.st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (q.st) q.f3 = 3'($urandom_range(0, 2));
        else      q.f3 = 3'($urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(4, 5));
      end else begin
        q.f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 4) == 0) q.rs1 = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      else                           q.rs1 = 32'($urandom_range(0, 140));
      imm_s  = int'($urandom_range(0, 80)) - 40;
      q.imm  = imm_s[11:0];
      q.rs2  = $urandom;
      q.rd   = 5'($urandom_range(0, 31));
      model_op(q, v);
      run_op(v, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    chk("rd/wr overlap count", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
